datapath_controller: RTL and testbench

//  Multicycle FSM that sequences the register-file/ALU datapath for one 16-bit instruction per s/w handshake.

---
 rtl/datapath_controller.sv | 141 ++++++++++++++
 tb/tb_datapath_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_controller.sv
// Multicycle sequencer for the register-file/ALU datapath: one 16-bit instruction per s/w handshake.
// Latches the instruction into IR, then walks read/ALU/write phases with Moore strobes decoded from state and IR.
//
// state  | meaning
// WAIT   | idle, w=1, accept instr when s=1
// DECODE | classify IR; unsupported opcode pulses illegal and returns to WAIT
// WRIMM  | write sign-extended imm8 into Rn
// GETA   | read Rn into A
// GETB   | read Rm into B
// ALU    | load C (or status flags for CMP)
// WRC    | write C into Rd
module datapath_controller #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              s,
   input  logic [15:0]       instr,
   output logic              w,
   output logic              illegal,
   output logic [REG_W-1:0]  readnum,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic [1:0]        shift,
   output logic [1:0]        aluop,
   output logic [REG_W-1:0]  writenum,
   output logic              write,
   output logic              vsel,
   output logic [DATA_W-1:0] sximm8
);

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_WRIMM  = 3'd2,
      S_GETA   = 3'd3,
      S_GETB   = 3'd4,
      S_ALU    = 3'd5,
      S_WRC    = 3'd6
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] ir;

   logic [2:0] opc;
   logic [1:0] op;
   logic       is_mov_imm, is_mov_reg, is_mvn, is_two_op, is_cmp;

   assign opc = ir[15:13];
   assign op  = ir[12:11];

   assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opc == 3'b110) && (op == 2'b00);
   assign is_mvn     = (opc == 3'b101) && (op == 2'b11);
   assign is_two_op  = (opc == 3'b101) && (op != 2'b11);
   assign is_cmp     = (opc == 3'b101) && (op == 2'b01);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= S_WAIT;
         ir    <= 16'h0000;
      end else begin
         state <= state_nxt;
         if (state == S_WAIT && s) ir <= instr;
      end
   end

   always_comb begin
      state_nxt = state;
      w         = 1'b0;
      illegal   = 1'b0;
      readnum   = '0;
      loada     = 1'b0;
      loadb     = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      asel      = 1'b0;
      writenum  = '0;
      write     = 1'b0;
      vsel      = 1'b0;
      unique case (state)
         S_WAIT: begin
            w = 1'b1;
            if (s) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (is_mov_imm)                state_nxt = S_WRIMM;
            else if (is_mov_reg || is_mvn) state_nxt = S_GETB;
            else if (is_two_op)            state_nxt = S_GETA;
            else begin
               illegal   = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WRIMM: begin
            writenum  = REG_W'(ir[10:8]);
            vsel      = 1'b1;
            write     = 1'b1;
            state_nxt = S_WAIT;
         end
         S_GETA: begin
            readnum   = REG_W'(ir[10:8]);
            loada     = 1'b1;
            state_nxt = S_GETB;
         end
         S_GETB: begin
            readnum   = REG_W'(ir[2:0]);
            loadb     = 1'b1;
            state_nxt = S_ALU;
         end
         S_ALU: begin
            // single-operand ops pass B through the ALU with A forced to zero
            asel = is_mov_reg || is_mvn;
            if (is_cmp) begin
               loads     = 1'b1;
               state_nxt = S_WAIT;
            end else begin
               loadc     = 1'b1;
               state_nxt = S_WRC;
            end
         end
         S_WRC: begin
            writenum  = REG_W'(ir[7:5]);
            write     = 1'b1;
            state_nxt = S_WAIT;
         end
         default: begin
            state_nxt = S_WAIT;
         end
      endcase
   end

   assign shift  = ir[4:3];
   assign aluop  = ir[12:11];
   assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: per-instruction phase-schedule model checked every cycle,
// plus directed literal checks for the documented instruction sequences.
module tb_datapath_controller;

   localparam int DATA_W = 16;
   localparam int REG_W  = 3;

   logic              clk;
   logic              resetn;
   logic              s;
   logic [15:0]       instr;
   logic              w, illegal, loada, loadb, loadc, loads, asel, write, vsel;
   logic [REG_W-1:0]  readnum, writenum;
   logic [1:0]        shift, aluop;
   logic [DATA_W-1:0] sximm8;

   int errors = 0;
   int checks = 0;

   datapath_controller #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clk(clk), .resetn(resetn), .s(s), .instr(instr),
      .w(w), .illegal(illegal), .readnum(readnum),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .shift(shift), .aluop(aluop),
      .writenum(writenum), .write(write), .vsel(vsel), .sximm8(sximm8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       w;
      logic       illegal;
      logic [2:0] readnum;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       write;
      logic [2:0] writenum;
      logic       vsel;
   } ph_t;

   localparam ph_t PH_IDLE = '{w: 1'b1, default: '0};

   ph_t         m_q[$];
   logic [15:0] m_ir = 16'h0000;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected cycle-by-cycle output schedule for one accepted instruction.
   function automatic void push_plan(input logic [15:0] ins);
      ph_t p_dec, p_a, p_b, p_alu, p_wr;
      logic [2:0] opc;
      logic [1:0] op;
      opc = ins[15:13];
      op  = ins[12:11];
      p_dec = '0;
      p_a = '0;  p_a.readnum = ins[10:8]; p_a.loada = 1'b1;
      p_b = '0;  p_b.readnum = ins[2:0];  p_b.loadb = 1'b1;
      p_alu = '0;
      p_wr = '0; p_wr.write = 1'b1; p_wr.writenum = ins[7:5];
      if (opc == 3'b110 && op == 2'b10) begin
         ph_t p_imm;
         p_imm = '0; p_imm.write = 1'b1; p_imm.vsel = 1'b1; p_imm.writenum = ins[10:8];
         m_q.push_back(p_dec); m_q.push_back(p_imm);
      end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
         p_alu.loadc = 1'b1; p_alu.asel = 1'b1;
         m_q.push_back(p_dec); m_q.push_back(p_b); m_q.push_back(p_alu); m_q.push_back(p_wr);
      end else if (opc == 3'b101 && op == 2'b01) begin
         p_alu.loads = 1'b1;
         m_q.push_back(p_dec); m_q.push_back(p_a); m_q.push_back(p_b); m_q.push_back(p_alu);
      end else if (opc == 3'b101) begin
         p_alu.loadc = 1'b1;
         m_q.push_back(p_dec); m_q.push_back(p_a); m_q.push_back(p_b); m_q.push_back(p_alu);
         m_q.push_back(p_wr);
      end else begin
         p_dec.illegal = 1'b1;
         m_q.push_back(p_dec);
      end
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_q.delete();
         m_ir = 16'h0000;
      end else if (m_q.size() == 0) begin
         if (s) begin
            m_ir = instr;
            push_plan(instr);
         end
      end else begin
         void'(m_q.pop_front());
      end
   end

   always @(negedge clk) begin
      ph_t exp_ph, act_ph;
      exp_ph = (m_q.size() == 0) ? PH_IDLE : m_q[0];
      act_ph = '{w, illegal, readnum, loada, loadb, loadc, loads, asel, write, writenum, vsel};
      chk("cycle_strobes", 64'(act_ph), 64'(exp_ph));
      chk("cycle_ir_fields", {28'h0, shift, aluop, sximm8},
          {28'h0, m_ir[4:3], m_ir[12:11], {{8{m_ir[7]}}, m_ir[7:0]}});
   end

   // Issue one instruction, then count busy cycles and check what the write stage sees.
   task automatic run_instr(input string name, input logic [15:0] ins, input int exp_lat,
                            input int exp_wr, input int exp_wnum, input logic exp_vsel,
                            input logic [15:0] exp_sx);
      int lat, wr;
      @(negedge clk);
      s = 1'b1; instr = ins;
      @(negedge clk);
      s = 1'b0; instr = ~ins;
      lat = 0; wr = 0;
      while (!w && lat < 20) begin
         lat++;
         if (write) begin
            wr++;
            chk({name, "_writenum"}, 64'(writenum), 64'(exp_wnum));
            chk({name, "_vsel"}, 64'(vsel), 64'(exp_vsel));
            if (exp_vsel) chk({name, "_sximm8"}, 64'(sximm8), 64'(exp_sx));
         end
         @(negedge clk);
      end
      chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({name, "_write_count"}, 64'(wr), 64'(exp_wr));
   endtask

   initial begin
      resetn = 1'b0;
      s      = 1'b0;
      instr  = 16'h0000;
      #22 resetn = 1'b1;
      @(negedge clk);
      chk("reset_w", 64'(w), 64'd1);
      chk("reset_sximm8", 64'(sximm8), 64'd0);

      run_instr("mov_imm5",  16'hD205, 2, 1, 2, 1'b1, 16'h0005);
      run_instr("mov_immm16", 16'hD1F0, 2, 1, 1, 1'b1, 16'hFFF0);
      run_instr("add",       16'hA0A2, 5, 1, 5, 1'b0, 16'h0000);
      run_instr("cmp",       16'hA902, 4, 0, 0, 1'b0, 16'h0000);
      run_instr("mvn",       16'hB8E3, 4, 1, 7, 1'b0, 16'h0000);
      run_instr("mov_reg",   16'hC0C9, 4, 1, 6, 1'b0, 16'h0000);

      // illegal opcode with s held high, next instruction accepted straight away
      @(negedge clk);
      s = 1'b1; instr = 16'hE000;
      @(negedge clk);
      chk("illegal_pulse", 64'(illegal), 64'd1);
      chk("illegal_no_strobes", 64'({loada, loadb, loadc, loads, write}), 64'd0);
      instr = 16'hD205;
      @(negedge clk);
      chk("illegal_then_w", 64'(w), 64'd1);
      chk("illegal_cleared", 64'(illegal), 64'd0);
      @(negedge clk);
      chk("b2b_accepted", 64'(w), 64'd0);
      s = 1'b0;
      @(negedge clk);
      chk("b2b_write", 64'({write, writenum}), 64'({1'b1, 3'd2}));
      @(negedge clk);
      chk("b2b_done", 64'(w), 64'd1);

      // async reset during GETB of an ADD
      @(negedge clk);
      s = 1'b1; instr = 16'hA0A2;
      @(negedge clk);
      s = 1'b0; instr = 16'h1234;
      @(negedge clk);
      chk("rst_geta", 64'({loada, readnum}), 64'({1'b1, 3'd0}));
      @(negedge clk);
      chk("rst_getb", 64'({loadb, readnum}), 64'({1'b1, 3'd2}));
      #1 resetn = 1'b0;
      #1;
      chk("rst_async_w", 64'(w), 64'd1);
      chk("rst_async_strobes", 64'({loadb, readnum, write, loadc}), 64'd0);
      @(negedge clk);
      #2 resetn = 1'b1;
      @(negedge clk);
      chk("rst_after_w", 64'(w), 64'd1);

      // randomized traffic with occasional async resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         case ($urandom_range(0, 3))
            0:       instr = {3'b110, 2'b10, 11'($urandom)};
            1:       instr = {3'b110, 2'b00, 11'($urandom)};
            2:       instr = {3'b101, 13'($urandom)};
            default: instr = 16'($urandom);
         endcase
         s = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 199) == 0) begin
            #2 resetn = 1'b0;
            @(negedge clk);
            #2 resetn = 1'b1;
         end
      end
      s = 1'b0;
      for (int i = 0; i < 10 && !w; i++) @(negedge clk);
      @(negedge clk);
      chk("final_idle", 64'(w), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
